// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between a requester and the apb_slave_mem completer.
// The requester drives the select/strobe/address/data lines; the completer answers with data, ready and error.
interface apb_slave_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a DEPTH x DATA_W register file with a fixed number of wait states,
// out-of-range error reporting and a sticky protocol-violation flag.
module apb_slave_mem #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic           pclk,
    input  logic           preset,
    apb_slave_mem_if.slave bus,
    output logic           prot_err
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              write_reg, write_next;
    logic              err_reg, err_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] prdata_reg, prdata_next;
    logic              pready_reg, pready_next;
    logic              pslverr_reg, pslverr_next;
    logic              prot_err_reg, prot_err_next;
    logic              mem_we;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  entry_we;

    // Response is built from the live bus in IDLE (zero-wait case) and from the latched request afterwards.
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_write;
    logic              ld_err;
    logic [DATA_W-1:0] ld_rdata;

    assign ld_addr  = (state_reg == ST_IDLE) ? bus.paddr  : addr_reg;
    assign ld_write = (state_reg == ST_IDLE) ? bus.pwrite : write_reg;
    assign ld_err   = ({1'b0, ld_addr} >= DEPTH_L);
    assign ld_rdata = (!ld_write && !ld_err) ? mem[ld_addr[IDX_W-1:0]] : '0;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        write_next    = write_reg;
        err_next      = err_reg;
        wdata_next    = wdata_reg;
        prdata_next   = prdata_reg;
        pready_next   = pready_reg;
        pslverr_next  = pslverr_reg;
        prot_err_next = prot_err_reg;
        mem_we        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    addr_next  = bus.paddr;
                    write_next = bus.pwrite;
                    wdata_next = bus.pwdata;
                    err_next   = ld_err;
                    if (WAIT_CYCLES == 0) begin
                        state_next   = ST_READY;
                        pready_next  = 1'b1;
                        pslverr_next = ld_err;
                        if (!ld_write) prdata_next = ld_rdata;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT_CYCLES - 1);
                    end
                end else if (bus.psel && bus.penable) begin
                    prot_err_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!(bus.psel && bus.penable)) begin
                    prot_err_next = 1'b1;
                    pready_next   = 1'b0;
                    pslverr_next  = 1'b0;
                    state_next    = ST_IDLE;
                end else if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    state_next   = ST_READY;
                    pready_next  = 1'b1;
                    pslverr_next = err_reg;
                    if (!write_reg) prdata_next = ld_rdata;
                end
            end
            ST_READY: begin
                if (bus.psel && bus.penable) begin
                    mem_we = write_reg && !err_reg;
                end else begin
                    prot_err_next = 1'b1;
                end
                pready_next  = 1'b0;
                pslverr_next = 1'b0;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            write_reg    <= 1'b0;
            err_reg      <= 1'b0;
            wdata_reg    <= '0;
            prdata_reg   <= '0;
            pready_reg   <= 1'b0;
            pslverr_reg  <= 1'b0;
            prot_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            write_reg    <= write_next;
            err_reg      <= err_next;
            wdata_reg    <= wdata_next;
            prdata_reg   <= prdata_next;
            pready_reg   <= pready_next;
            pslverr_reg  <= pslverr_next;
            prot_err_reg <= prot_err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = mem_we && (addr_reg[IDX_W-1:0] == IDX_W'(gi));
        end
    endgenerate

    // Register file clears on reset so a post-reset read never exposes stale data.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) mem[i] <= wdata_reg;
            end
        end
    end

    assign bus.prdata  = prdata_reg;
    assign bus.pready  = pready_reg;
    assign bus.pslverr = pslverr_reg;
    assign prot_err    = prot_err_reg;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances with 0, 2 and 3 wait states share the bus lines,
// a scoreboard queue holds the expected response of every transfer until the completer answers.
module tb_apb_slave_mem;
    logic       pclk;
    logic       preset;
    logic [2:0] sel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [2:0] prot_err_w;

    logic       pready_w  [3];
    logic       pslverr_w [3];
    logic [7:0] prdata_w  [3];

    apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
    apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
    apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

    assign bus0.psel = sel[0];
    assign bus1.psel = sel[1];
    assign bus2.psel = sel[2];
    assign bus0.penable = penable;
    assign bus1.penable = penable;
    assign bus2.penable = penable;
    assign bus0.pwrite = pwrite;
    assign bus1.pwrite = pwrite;
    assign bus2.pwrite = pwrite;
    assign bus0.paddr = paddr;
    assign bus1.paddr = paddr;
    assign bus2.paddr = paddr;
    assign bus0.pwdata = pwdata;
    assign bus1.pwdata = pwdata;
    assign bus2.pwdata = pwdata;

    assign pready_w[0]  = bus0.pready;
    assign pready_w[1]  = bus1.pready;
    assign pready_w[2]  = bus2.pready;
    assign pslverr_w[0] = bus0.pslverr;
    assign pslverr_w[1] = bus1.pslverr;
    assign pslverr_w[2] = bus2.pslverr;
    assign prdata_w[0]  = bus0.prdata;
    assign prdata_w[1]  = bus1.prdata;
    assign prdata_w[2]  = bus2.prdata;

    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .preset(preset), .bus(bus0.slave), .prot_err(prot_err_w[0]));
    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(2)) dut1 (
        .pclk(pclk), .preset(preset), .bus(bus1.slave), .prot_err(prot_err_w[1]));
    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(3)) dut2 (
        .pclk(pclk), .preset(preset), .bus(bus2.slave), .prot_err(prot_err_w[2]));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        int         dut;
        logic       wr;
        logic       err;
        logic [7:0] rdata;
        int         waits;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [3][64];
    int         wait_of [3] = '{0, 2, 3};
    int         checks = 0;
    int         errors = 0;
    int         completions = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        sel     = 3'b000;
        penable = 1'b0;
    endtask

    // One complete transfer; leaves the bus right after the completion edge so callers can chain transfers.
    task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        exp_t e;
        exp_t got;
        int   waits;
        bit   timed_out;
        e.dut   = d;
        e.wr    = wr;
        e.err   = (addr >= 8'd64);
        e.rdata = (!wr && !e.err) ? model[d][addr[5:0]] : 8'h00;
        e.waits = wait_of[d];
        sb.push_back(e);

        sel      = 3'b000;
        sel[d]   = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = addr;
        pwdata   = wdata;
        @(posedge pclk);
        #1;
        penable  = 1'b1;
        paddr    = addr ^ 8'h01;
        pwdata   = ~wdata;

        waits     = 0;
        timed_out = 1'b0;
        forever begin
            @(negedge pclk);
            if (pready_w[d] === 1'b1) break;
            waits++;
            if (waits > 20) begin
                timed_out = 1'b1;
                break;
            end
        end
        check($sformatf("dut%0d %s @%0h pready timeout", d, wr ? "wr" : "rd", addr), 32'(timed_out), 32'd0);
        if (sb.size() == 0) begin
            check("scoreboard underflow", 32'd1, 32'd0);
            return;
        end
        got = sb.pop_front();
        if (timed_out) return;
        check($sformatf("dut%0d %s @%0h wait cycles", d, wr ? "wr" : "rd", addr), 32'(waits), 32'(got.waits));
        check($sformatf("dut%0d %s @%0h pslverr", d, wr ? "wr" : "rd", addr), 32'(pslverr_w[d]), 32'(got.err));
        if (!got.wr)
            check($sformatf("dut%0d rd @%0h prdata", d, addr), 32'(prdata_w[d]), 32'(got.rdata));
        @(posedge pclk);
        #1;
        if (got.wr && !got.err) model[d][addr[5:0]] = wdata;
        completions++;
    endtask

    initial begin
        int n0;
        int high_seen;
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 64; a++) model[d][a] = 8'h00;

        preset = 1'b1;
        go_idle();
        pwrite = 1'b0;
        paddr  = 8'h00;
        pwdata = 8'h00;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d reset pready", d), 32'(pready_w[d]), 32'd0);
            check($sformatf("dut%0d reset pslverr", d), 32'(pslverr_w[d]), 32'd0);
            check($sformatf("dut%0d reset prdata", d), 32'(prdata_w[d]), 32'd0);
            check($sformatf("dut%0d reset prot_err", d), 32'(prot_err_w[d]), 32'd0);
        end
        @(posedge pclk);
        #1;

        // Zero-wait write then read back.
        xfer(0, 1'b1, 8'h10, 8'hA5);
        xfer(0, 1'b0, 8'h10, 8'h00);
        go_idle();
        @(posedge pclk); #1;

        // Two wait states.
        xfer(1, 1'b1, 8'h10, 8'hA5);
        go_idle();
        @(posedge pclk); #1;
        xfer(1, 1'b0, 8'h10, 8'h00);
        go_idle();
        @(posedge pclk); #1;

        // Out-of-range boundary at DEPTH, plus the last valid entry.
        xfer(0, 1'b1, 8'h40, 8'h3C);
        xfer(0, 1'b0, 8'h40, 8'h00);
        xfer(0, 1'b0, 8'h00, 8'h00);
        xfer(0, 1'b1, 8'h3F, 8'h5A);
        xfer(0, 1'b0, 8'h3F, 8'h00);
        xfer(0, 1'b0, 8'hFF, 8'h00);
        go_idle();
        @(posedge pclk); #1;

        // Back-to-back with no idle cycles.
        n0 = completions;
        xfer(0, 1'b1, 8'h05, 8'h11);
        xfer(0, 1'b1, 8'h05, 8'h22);
        xfer(0, 1'b0, 8'h05, 8'h00);
        go_idle();
        check("back-to-back completions", 32'(completions - n0), 32'd3);
        @(posedge pclk); #1;

        // Abort during the second wait cycle of a write on the 3-wait instance.
        high_seen = 0;
        sel     = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h07;
        pwdata  = 8'hFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        if (pready_w[2] !== 1'b0) high_seen++;
        @(posedge pclk); #1;
        go_idle();
        repeat (5) begin
            @(negedge pclk);
            if (pready_w[2] !== 1'b0) high_seen++;
        end
        check("abort pready high cycles", 32'(high_seen), 32'd0);
        check("abort prot_err dut2", 32'(prot_err_w[2]), 32'd1);
        check("abort prot_err dut0 untouched", 32'(prot_err_w[0]), 32'd0);
        @(posedge pclk); #1;
        xfer(2, 1'b0, 8'h07, 8'h00);
        go_idle();
        check("prot_err sticky after good read", 32'(prot_err_w[2]), 32'd1);
        @(posedge pclk); #1;

        // Access phase with no setup phase from IDLE.
        sel     = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 8'h05;
        @(posedge pclk); #1;
        go_idle();
        @(negedge pclk);
        check("no-setup prot_err dut0", 32'(prot_err_w[0]), 32'd1);
        check("no-setup pready dut0", 32'(pready_w[0]), 32'd0);
        @(posedge pclk); #1;

        // Reset in the middle of a wait-state write.
        sel     = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h10;
        pwdata  = 8'h77;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        preset = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d mid-reset pready", d), 32'(pready_w[d]), 32'd0);
            check($sformatf("dut%0d mid-reset prdata", d), 32'(prdata_w[d]), 32'd0);
            check($sformatf("dut%0d mid-reset prot_err", d), 32'(prot_err_w[d]), 32'd0);
        end
        go_idle();
        @(negedge pclk);
        preset = 1'b0;
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 64; a++) model[d][a] = 8'h00;
        @(posedge pclk); #1;
        xfer(0, 1'b0, 8'h05, 8'h00);
        xfer(0, 1'b0, 8'h10, 8'h00);
        xfer(0, 1'b0, 8'h3F, 8'h00);
        go_idle();
        @(posedge pclk); #1;
        xfer(1, 1'b0, 8'h10, 8'h00);
        go_idle();
        @(posedge pclk); #1;
        xfer(2, 1'b0, 8'h07, 8'h00);
        go_idle();
        @(posedge pclk); #1;

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
